// File: rtl/ledm_pkg.sv
// Shared definitions for the LED-matrix row-scan interface.
// Holds the default matrix geometry (shared with the LEDMatrix_m driver)
// and the receiver FSM state encoding.
package ledm_pkg;

  localparam int unsigned COLS_DEF  = 32;
  localparam int unsigned ROWS_DEF  = 16;
  localparam int unsigned ROW_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FULL,
    S_OVER
  } state_t;

endpackage

// File: rtl/ledm_edge_det.sv
// Rising-edge detector for a scan strobe (sclk or latch).
// Optional macro LEDM_RX_SYNC_EN inserts a 2-flop synchroniser ahead of
// the input register for asynchronous pins.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   din  - strobe input
//   rise - one-cycle registered pulse on each rising edge of din
module ledm_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic d_in;

`ifdef LEDM_RX_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], din};
  end

  assign d_in = sync[1];
`else
  assign d_in = din;
`endif

  logic q1, q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1   <= 1'b0;
      q2   <= 1'b0;
      rise <= 1'b0;
    end else begin
      q1   <= d_in;
      q2   <= q1;
      rise <= q1 & ~q2;
    end
  end

endmodule

// File: rtl/led_matrix_scan_rx.sv
// Receiver for the LED-matrix row-scan interface. Oversamples sclk, sdata,
// latch and row_addr on clk, deserialises each row (MSB first) and emits one
// row word per latch, a frame_done pulse after a clean frame, and pulses for
// wrong bit counts (len_err) and out-of-order rows (seq_err).
// Optional macro LEDM_RX_SYNC_EN adds input synchronisers (+2 cycles latency).
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   sclk, sdata       - shift clock and serial column data
//   latch, row_addr   - row latch strobe and row being latched
//   row_we, row_idx, row_data - row write strobe, index, captured row
//   frame_done, len_err, seq_err - frame/protocol status pulses
module led_matrix_scan_rx
  import ledm_pkg::*;
#(
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             sdata,
  input  logic             latch,
  input  logic [ROW_W-1:0] row_addr,
  output logic             row_we,
  output logic [ROW_W-1:0] row_idx,
  output logic [COLS-1:0]  row_data,
  output logic             frame_done,
  output logic             len_err,
  output logic             seq_err
);

  localparam int unsigned CNT_W = $clog2(COLS + 1);

  logic sclk_rise, latch_rise;

  ledm_edge_det u_sclk_det  (.clk(clk), .rst(rst), .din(sclk),  .rise(sclk_rise));
  ledm_edge_det u_latch_det (.clk(clk), .rst(rst), .din(latch), .rise(latch_rise));

  // Data path delayed to line up with the registered rise pulses.
  logic [ROW_W:0] data_in, d1, d2;

`ifdef LEDM_RX_SYNC_EN
  logic [ROW_W:0] dsync0, dsync1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsync0 <= '0;
      dsync1 <= '0;
    end else begin
      dsync0 <= {row_addr, sdata};
      dsync1 <= dsync0;
    end
  end

  assign data_in = dsync1;
`else
  assign data_in = {row_addr, sdata};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= data_in;
      d2 <= d1;
    end
  end

  logic             sdata_al;
  logic [ROW_W-1:0] addr_al;
  assign sdata_al = d2[0];
  assign addr_al  = d2[ROW_W:1];

  state_t           state, state_nx;
  logic [CNT_W-1:0] count;
  logic [COLS-1:0]  shreg;
  logic             do_shift, row_ok, row_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Latch has priority, so a coincident sclk rise is dropped.
  always_comb begin
    state_nx = state;
    if (latch_rise) begin
      state_nx = S_IDLE;
    end else if (sclk_rise) begin
      unique case (state)
        S_IDLE, S_SHIFT: state_nx = (count == CNT_W'(COLS - 1)) ? S_FULL : S_SHIFT;
        S_FULL, S_OVER:  state_nx = S_OVER;
        default:         state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    do_shift = 1'b0;
    row_ok   = 1'b0;
    row_bad  = 1'b0;
    if (latch_rise) begin
      row_ok  = (state == S_FULL);
      row_bad = (state != S_FULL);
    end else if (sclk_rise) begin
      do_shift = (state == S_IDLE) || (state == S_SHIFT);
    end
  end

  logic             frame_ok, seq_bad;
  logic [ROW_W-1:0] expected;
  logic             ev_we, ev_len, ev_seq, ev_done, done_d;
  logic [ROW_W-1:0] ev_idx;
  logic [COLS-1:0]  ev_data;

  assign seq_bad = (addr_al != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      shreg    <= '0;
      expected <= '0;
      frame_ok <= 1'b1;
      ev_we    <= 1'b0;
      ev_len   <= 1'b0;
      ev_seq   <= 1'b0;
      ev_done  <= 1'b0;
      ev_idx   <= '0;
      ev_data  <= '0;
    end else begin
      if (latch_rise)    count <= '0;
      else if (do_shift) count <= count + CNT_W'(1);
      if (do_shift) shreg <= {shreg[COLS-2:0], sdata_al};

      ev_we   <= row_ok;
      ev_len  <= row_bad;
      ev_seq  <= row_ok & seq_bad;
      ev_done <= 1'b0;

      if (row_bad) frame_ok <= 1'b0;
      if (row_ok) begin
        ev_idx   <= addr_al;
        ev_data  <= shreg;
        expected <= addr_al + ROW_W'(1);
        // Last row closes the frame and re-arms the clean-frame flag.
        if (addr_al == ROW_W'(ROWS - 1)) begin
          ev_done  <= frame_ok & ~seq_bad;
          frame_ok <= 1'b1;
        end else if (seq_bad) begin
          frame_ok <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_we     <= 1'b0;
      row_idx    <= '0;
      row_data   <= '0;
      len_err    <= 1'b0;
      seq_err    <= 1'b0;
      done_d     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_we     <= ev_we;
      row_idx    <= ev_idx;
      row_data   <= ev_data;
      len_err    <= ev_len;
      seq_err    <= ev_seq;
      done_d     <= ev_done;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_rx.sv
// Directed self-checking bench for led_matrix_scan_rx.
module tb_led_matrix_scan_rx;

`ifdef LEDM_RX_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst, sclk, sdata, latch;
  logic [3:0]  row_addr;
  logic        row_we, frame_done, len_err, seq_err;
  logic [3:0]  row_idx;
  logic [31:0] row_data;

  led_matrix_scan_rx #(.COLS(32), .ROWS(16), .ROW_W(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdata(sdata), .latch(latch),
    .row_addr(row_addr), .row_we(row_we), .row_idx(row_idx),
    .row_data(row_data), .frame_done(frame_done), .len_err(len_err),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_we = 0, n_len = 0, n_seq = 0, n_fd = 0;
  int we_cyc = 0, len_cyc = 0, seq_cyc = 0, fd_cyc = 0;
  logic [3:0]  last_idx = '0;
  logic [31:0] last_data = '0;

  always @(negedge clk) begin
    if (row_we)     begin n_we++;  we_cyc = cyc; last_idx = row_idx; last_data = row_data; end
    if (len_err)    begin n_len++; len_cyc = cyc; end
    if (seq_err)    begin n_seq++; seq_cyc = cyc; end
    if (frame_done) begin n_fd++;  fd_cyc = cyc; end
  end

  int total = 0, bad = 0;
  int t0 = 0;
  int b_we, b_len, b_seq, b_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_we = n_we; b_len = n_len; b_seq = n_seq; b_fd = n_fd;
  endtask

  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0; sdata = d[i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic latch_row(input logic [3:0] a);
    row_addr = a; latch = 1'b1;
    t0 = cyc + 1;
    repeat (LAT + 3) @(negedge clk);
    latch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_row(input logic [3:0] a, input logic [31:0] d);
    send_bits({32'h0, d}, 32);
    latch_row(a);
  endtask

  task automatic do_reset();
    rst = 1'b1; sclk = 1'b0; latch = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; sdata = 1'b0; latch = 1'b0; row_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_row_we", 32'(row_we), 32'd0);
    check("rst_row_idx", 32'(row_idx), 32'd0);
    check("rst_row_data", row_data, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single row 0
    snap();
    send_row(4'd0, 32'hA5A5_0F0F);
    check("t1_we_cnt", 32'(n_we - b_we), 32'd1);
    check("t1_idx", 32'(last_idx), 32'd0);
    check("t1_data", last_data, 32'hA5A5_0F0F);
    check("t1_latency", 32'(we_cyc - t0), 32'(LAT));
    check("t1_len", 32'(n_len - b_len), 32'd0);
    check("t1_seq", 32'(n_seq - b_seq), 32'd0);

    // Clean frame
    do_reset();
    snap();
    for (int r = 0; r < 16; r++) send_row(4'(r), 32'(r));
    check("t2_we_cnt", 32'(n_we - b_we), 32'd16);
    check("t2_seq", 32'(n_seq - b_seq), 32'd0);
    check("t2_fd_cnt", 32'(n_fd - b_fd), 32'd1);
    check("t2_fd_delay", 32'(fd_cyc - we_cyc), 32'd1);
    check("t2_last_idx", 32'(last_idx), 32'd15);
    check("t2_last_data", last_data, 32'd15);

    // 31-bit row inside a frame
    snap();
    for (int r = 0; r < 5; r++) send_row(4'(r), 32'h100 + 32'(r));
    send_bits(64'h7FFF_FFFF, 31);
    latch_row(4'd5);
    check("t3a_len_cnt", 32'(n_len - b_len), 32'd1);
    check("t3a_len_latency", 32'(len_cyc - t0), 32'(LAT));
    check("t3a_no_we", 32'(n_we - b_we), 32'd5);
    for (int r = 5; r < 16; r++) send_row(4'(r), 32'h100 + 32'(r));
    check("t3a_fd", 32'(n_fd - b_fd), 32'd0);
    check("t3a_seq", 32'(n_seq - b_seq), 32'd0);
    check("t3a_we_cnt", 32'(n_we - b_we), 32'd16);
    snap();
    for (int r = 0; r < 16; r++) send_row(4'(r), 32'h200 + 32'(r));
    check("t3a_next_fd", 32'(n_fd - b_fd), 32'd1);

    // 33-bit row inside a frame
    snap();
    for (int r = 0; r < 8; r++) send_row(4'(r), 32'h300 + 32'(r));
    send_bits(64'h1_2345_6789, 33);
    latch_row(4'd8);
    check("t3b_len_cnt", 32'(n_len - b_len), 32'd1);
    check("t3b_no_we", 32'(n_we - b_we), 32'd8);
    for (int r = 8; r < 16; r++) send_row(4'(r), 32'h300 + 32'(r));
    check("t3b_fd", 32'(n_fd - b_fd), 32'd0);
    check("t3b_we_cnt", 32'(n_we - b_we), 32'd16);
    snap();
    for (int r = 0; r < 16; r++) send_row(4'(r), 32'h400 + 32'(r));
    check("t3b_next_fd", 32'(n_fd - b_fd), 32'd1);
    check("t3b_next_len", 32'(n_len - b_len), 32'd0);

    // Sequence error: row 2 skipped
    snap();
    send_row(4'd0, 32'h500);
    send_row(4'd1, 32'h501);
    send_row(4'd3, 32'h503);
    check("t4_seq_on_row3", 32'(n_seq - b_seq), 32'd1);
    check("t4_seq_with_we", 32'(seq_cyc - we_cyc), 32'd0);
    check("t4_row3_idx", 32'(last_idx), 32'd3);
    for (int r = 4; r < 16; r++) send_row(4'(r), 32'h500 + 32'(r));
    check("t4_seq_total", 32'(n_seq - b_seq), 32'd1);
    check("t4_we_cnt", 32'(n_we - b_we), 32'd15);
    check("t4_fd", 32'(n_fd - b_fd), 32'd0);
    snap();
    for (int r = 0; r < 16; r++) send_row(4'(r), 32'h600 + 32'(r));
    check("t4_next_fd", 32'(n_fd - b_fd), 32'd1);
    check("t4_next_seq", 32'(n_seq - b_seq), 32'd0);

    // Coincident sclk rise and latch rise
    do_reset();
    snap();
    send_bits({32'h0, 32'h1234_5678}, 32);
    sclk = 1'b0; sdata = 1'b1;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    latch_row(4'd0);
    check("t5_data", last_data, 32'h1234_5678);
    check("t5_len", 32'(n_len - b_len), 32'd0);
    send_row(4'd1, 32'hDEAD_BEEF);
    check("t5_next_data", last_data, 32'hDEAD_BEEF);
    check("t5_next_idx", 32'(last_idx), 32'd1);
    check("t5_next_len", 32'(n_len - b_len), 32'd0);
    check("t5_we_cnt", 32'(n_we - b_we), 32'd2);

    // Reset mid-row, then static inputs, then a fresh row 0
    do_reset();
    for (int r = 0; r < 3; r++) send_row(4'(r), 32'(r) + 32'h700);
    send_bits(64'h3FF, 10);
    #2;
    rst = 1'b1; sclk = 1'b0; latch = 1'b0;
    #1;
    check("t6_rst_data", row_data, 32'd0);
    check("t6_rst_idx", 32'(row_idx), 32'd0);
    check("t6_rst_flags", {28'd0, row_we, frame_done, len_err, seq_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (20) @(negedge clk);
    check("t6_static", 32'((n_we - b_we) + (n_len - b_len) + (n_seq - b_seq) + (n_fd - b_fd)), 32'd0);
    send_row(4'd0, 32'hCAFE_F00D);
    check("t6_data", last_data, 32'hCAFE_F00D);
    check("t6_we_cnt", 32'(n_we - b_we), 32'd1);
    check("t6_seq", 32'(n_seq - b_seq), 32'd0);
    check("t6_len", 32'(n_len - b_len), 32'd0);
    check("t6_latency", 32'(we_cyc - t0), 32'(LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_rx.md
Name: led_matrix_scan_rx

Overview:
- Receiving end of the LED-matrix row-scan interface that LEDMatrix_m drives: serial column data, shift clock, latch and row address.
- Oversamples those signals on the system clock and deserialises each row. Emits one row word per latch and flags frame completion and protocol errors.
- Serves as the loop-back checker/capture block in matrix benches, and as the input stage of a downstream frame store.

Parameters:
- COLS, 32, columns per row (bits shifted per latch); ≥2.
- ROWS, 16, rows per frame; power of two.
- ROW_W, 4, row address width; equals log2(ROWS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  scan shift clock, synchronous to clk and at least 4 clk periods per full cycle; data is taken on its rising edge.
- sdata  in  1  serial column data, MSB (column COLS-1) first.
- latch  in  1  row latch strobe; its rising edge ends the row.
- row_addr  in  ROW_W  row being latched; stable while latch is high.
- row_we  out  1  one-cycle row-write strobe.
- row_idx  out  ROW_W  row index for row_we.
- row_data  out  COLS  captured row; bit i = column i.
- frame_done  out  1  one-cycle pulse after the last row of a clean frame.
- len_err  out  1  one-cycle pulse: latch arrived with the wrong bit count.
- seq_err  out  1  one-cycle pulse: row arrived out of order.

Behaviour:
- Reset: every output is 0. Internal state is cleared: shift register 0, bit count 0, expected row 0, frame_ok 1, FSM in S_IDLE.
- Input stage:
  - sclk, sdata, latch and row_addr are registered once.
  - Edges are detected by comparing that register with a second delayed copy.
- FSM states and transitions:
  - S_IDLE → S_SHIFT on the first sclk rise.
  - S_SHIFT: each sclk rise shifts sdata into bit 0 and increments the count. When the count reaches COLS, go to S_FULL.
  - S_FULL: a further sclk rise goes to S_OVER; the data is not shifted.
  - S_OVER: absorbs further sclk rises.
  - Latch rise in any state: evaluate the row, clear the count, go to S_IDLE.
- Latch evaluation:
  - In S_FULL: row_we=1, row_data=shift register, row_idx=latched row_addr.
  - In any other state, including S_IDLE (zero bits): no write, len_err=1, frame_ok cleared.
- Latency: row_we, len_err and seq_err assert exactly 3 clk cycles after the first clk edge at which latch is sampled high.
- Sequence check on a valid row:
  - If row_addr ≠ expected: seq_err=1 and frame_ok cleared.
  - In all cases, expected becomes row_addr+1 modulo ROWS (wrap ROWS-1→0).
- Frame completion on a valid row with row_addr=ROWS-1:
  - frame_done pulses one cycle after that row_we, only if frame_ok was still 1.
  - frame_ok then returns to 1 whether or not frame_done fired.
- A frame whose first error is on row ROWS-1 does not fire frame_done.
- Simultaneous sclk rise and latch rise: the latch wins and the sclk rise is dropped (not counted, not shifted).
- sclk and latch inputs held static: no outputs change.
- Reset asserted mid-row: the partial row is discarded with no strobes, and outputs go to 0 immediately.

Optional Feature:
- LEDM_RX_SYNC_EN defined:
  - A 2-flop synchroniser is inserted ahead of the input stage on sclk, sdata, latch and row_addr, for asynchronous external pins.
  - All latencies grow by 2 cycles, i.e. 5 cycles latch-to-row_we.
- Undefined: no synchroniser; inputs must be clk-synchronous; latency 3 cycles.

Decomposition:
- Shared package ledm_pkg holds:
  - default COLS, ROWS and ROW_W constants, shared with LEDMatrix_m;
  - the FSM state enum (S_IDLE, S_SHIFT, S_FULL, S_OVER).
- One natural sub-module, ledm_edge_det:
  - input register plus optional synchroniser;
  - rise-detect pulse per strobe;
  - instantiated for sclk and latch.

Test Plan:
- Row 0, 32 bits of 0xA5A5_0F0F MSB first, then latch → row_we=1, row_idx=0, row_data=0xA5A50F0F, 3 cycles after latch sampled; no errors.
- Rows 0..15 in order, each with data = row number → 16 row_we pulses and one frame_done one cycle after row 15's row_we; seq_err never asserts.
- Row with 31 bits, then latch; separately, a row with 33 bits, then latch → len_err=1 each time, no row_we; the following frame's frame_done is suppressed only if the error fell within that frame.
- Rows 0,1,3,4..15 → seq_err on row 3; all rows still written; frame_done=0; next clean frame 0..15 → frame_done=1.
- sclk rise coincident with latch rise after 32 bits → row written with the first 32 bits only; the next row's count starts at 0.
- rst pulsed after 10 bits → all outputs 0; the next full row 0 decodes correctly with expected row 0. Repeat all cases with LEDM_RX_SYNC_EN, checking 5-cycle latency.
